// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception codes,
// Status/Cause field positions and word-packing helpers.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    function automatic logic [31:0] pack_status(input logic ie, input logic exl,
                                                input logic [7:0] im);
        logic [31:0] w;
        w = '0;
        w[STATUS_IE]                  = ie;
        w[STATUS_EXL]                 = exl;
        w[STATUS_IM_HI:STATUS_IM_LO]  = im;
        return w;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]                   = bd;
        w[CAUSE_TI]                   = ti;
        w[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare register and the
// sticky timer interrupt flag TI.
module cp0_count_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   count_inc;
    logic          ti_set;

    assign tick      = (presc == PRESC_LAST);
    assign count_inc = count + 32'd1;
    // An MTC0 to Count suppresses this cycle's increment, so it cannot raise TI.
    assign ti_set    = !count_we && tick && (count_inc == compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                presc <= '0;
                count <= wr_data;
            end else if (tick) begin
                presc <= '0;
                count <= count_inc;
            end else begin
                presc <= presc + PW'(1);
            end

            if (compare_we) begin
                compare <= wr_data;
            end

            // Clearing through Compare has priority over a coincident match.
            if (compare_we) begin
                ti <= 1'b0;
            end else if (ti_set) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_irq_timer.sv
// Coprocessor-0 register file with interrupt/exception arbitration at commit.
// Drives the redirect (take_exc) and the EPC used for ERET.
module cp0_irq_timer
    import cp0_pkg::*;
#(
    parameter int NUM_HW_IRQ  = 6,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            rd_addr,
    input  logic [2:0]            rd_sel,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [2:0]            wr_sel,
    input  logic [31:0]           wr_data,
    input  logic [NUM_HW_IRQ-1:0] hw_irq,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_badvaddr_we,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    input  logic                  pipe_stall,
    output logic                  take_exc,
    output logic [31:0]           epc_out,
    output logic                  timer_irq
);

    logic [NUM_HW_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [5:0]            hw_ip;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= hw_irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        hw_ip = '0;
        hw_ip[NUM_HW_IRQ-1:0] = sync_q[SYNC_STAGES-1];
    end

    logic wr_base;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    assign wr_base    = wr_en && (wr_sel == 3'd0);
    assign wr_count   = wr_base && (wr_addr == CP0_COUNT);
    assign wr_compare = wr_base && (wr_addr == CP0_COMPARE);
    assign wr_status  = wr_base && (wr_addr == CP0_STATUS);
    assign wr_cause   = wr_base && (wr_addr == CP0_CAUSE);
    assign wr_epc     = wr_base && (wr_addr == CP0_EPC);

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    cp0_count_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_count_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    logic [31:0] badvaddr;
    logic        st_ie;
    logic        st_exl;
    logic [7:0]  st_im;
    logic        ca_bd;
    logic [4:0]  ca_exc;
    logic [1:0]  ca_ipsw;
    logic [31:0] epc;

    // Post-bypass views: a committing MTC0 is already visible to the interrupt
    // decision and to readers in the same cycle.
    logic        ie_pb;
    logic        exl_pb;
    logic [7:0]  im_pb;
    logic [1:0]  ipsw_pb;
    logic [7:0]  ip_pb;
    logic        int_pending;

    assign ie_pb   = wr_status ? wr_data[STATUS_IE]                 : st_ie;
    assign exl_pb  = wr_status ? wr_data[STATUS_EXL]                : st_exl;
    assign im_pb   = wr_status ? wr_data[STATUS_IM_HI:STATUS_IM_LO] : st_im;
    assign ipsw_pb = wr_cause  ? wr_data[CAUSE_IP_LO+1:CAUSE_IP_LO] : ca_ipsw;
    assign ip_pb   = {hw_ip[5] | ti, hw_ip[4:0], ipsw_pb};

    assign int_pending = ie_pb && !exl_pb && (|(ip_pb & im_pb));

    // The blocking EXL is the registered one: an MTC0 cannot unblock itself.
    assign take_exc  = (exc_valid || int_pending) && !st_exl && !pipe_stall;
    assign epc_out   = wr_epc ? wr_data : epc;
    assign timer_irq = ti;

    logic [31:0] epc_next;
    logic [4:0]  exc_code_next;

    assign epc_next      = exc_bd ? (exc_pc - 32'd4) : exc_pc;
    assign exc_code_next = exc_valid ? exc_code : 5'(EXC_INT);

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr <= '0;
            st_ie    <= 1'b0;
            st_exl   <= 1'b0;
            st_im    <= '0;
            ca_bd    <= 1'b0;
            ca_exc   <= '0;
            ca_ipsw  <= '0;
            epc      <= '0;
        end else begin
            if (wr_status) begin
                st_ie <= wr_data[STATUS_IE];
                st_im <= wr_data[STATUS_IM_HI:STATUS_IM_LO];
            end

            if (take_exc) begin
                st_exl <= 1'b1;
            end else if (eret) begin
                st_exl <= 1'b0;
            end else if (wr_status) begin
                st_exl <= wr_data[STATUS_EXL];
            end

            if (wr_cause) begin
                ca_ipsw <= wr_data[CAUSE_IP_LO+1:CAUSE_IP_LO];
            end

            if (take_exc) begin
                ca_bd  <= exc_bd;
                ca_exc <= exc_code_next;
                epc    <= epc_next;
            end else if (wr_epc) begin
                epc <= wr_data;
            end

            if (take_exc && exc_valid && exc_badvaddr_we) begin
                badvaddr <= exc_badvaddr;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_sel == 3'd0) begin
            case (rd_addr)
                CP0_BADVADDR: rd_data = badvaddr;
                CP0_COUNT:    rd_data = wr_count ? wr_data : count;
                CP0_COMPARE:  rd_data = wr_compare ? wr_data : compare;
                CP0_STATUS:   rd_data = pack_status(ie_pb, exl_pb, im_pb);
                CP0_CAUSE:    rd_data = pack_cause(ca_bd, ti, ip_pb, ca_exc);
                CP0_EPC:      rd_data = epc_out;
                default:      rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed + randomized bench for cp0_irq_timer against a behavioural CP0 model.
module tb_cp0_irq_timer;

    localparam int NHW = 6;
    localparam int DIV = 2;
    localparam int SS  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [NHW-1:0] hw_irq;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic        exc_badvaddr_we;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        pipe_stall;
    logic        take_exc;
    logic [31:0] epc_out;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cp0_irq_timer #(
        .NUM_HW_IRQ  (NHW),
        .COUNT_DIV   (DIV),
        .SYNC_STAGES (SS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_addr         (rd_addr),
        .rd_sel          (rd_sel),
        .rd_data         (rd_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_sel          (wr_sel),
        .wr_data         (wr_data),
        .hw_irq          (hw_irq),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .exc_bd          (exc_bd),
        .exc_pc          (exc_pc),
        .exc_badvaddr_we (exc_badvaddr_we),
        .exc_badvaddr    (exc_badvaddr),
        .eret            (eret),
        .pipe_stall      (pipe_stall),
        .take_exc        (take_exc),
        .epc_out         (epc_out),
        .timer_irq       (timer_irq)
    );

    // Behavioural model: Count is derived arithmetically from the last load value
    // and the number of edges elapsed since that load.
    logic [31:0] m_badv, m_base, m_compare, m_epc;
    int          m_elapsed;
    logic        m_ti, m_ie, m_exl, m_bd;
    logic [7:0]  m_im;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hist [SS];

    function automatic logic hit(input logic [4:0] a);
        return wr_en && (wr_sel == 3'd0) && (wr_addr == a);
    endfunction

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_elapsed / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [5:0] hw;
        logic [1:0] sw;
        hw = m_hist[SS-1];
        sw = hit(5'd13) ? wr_data[9:8] : m_ipsw;
        return {hw[5] | m_ti, hw[4:0], sw};
    endfunction

    function automatic logic e_take();
        logic ie, exl, pend;
        logic [7:0] im;
        ie   = hit(5'd12) ? wr_data[0]    : m_ie;
        exl  = hit(5'd12) ? wr_data[1]    : m_exl;
        im   = hit(5'd12) ? wr_data[15:8] : m_im;
        pend = ie && !exl && (|(m_ip() & im));
        return (exc_valid || pend) && !m_exl && !pipe_stall;
    endfunction

    function automatic logic [31:0] e_epc();
        return hit(5'd14) ? wr_data : m_epc;
    endfunction

    function automatic logic [31:0] e_rd();
        logic [31:0] st;
        st = hit(5'd12) ? {16'h0, wr_data[15:8], 6'h0, wr_data[1:0]}
                        : {16'h0, m_im, 6'h0, m_exl, m_ie};
        if (rd_sel != 3'd0) return 32'h0;
        case (rd_addr)
            5'd8:    return m_badv;
            5'd9:    return hit(5'd9) ? wr_data : m_count();
            5'd11:   return hit(5'd11) ? wr_data : m_compare;
            5'd12:   return st;
            5'd13:   return {m_bd, m_ti, 14'h0, m_ip(), 1'b0, m_exc, 2'b00};
            5'd14:   return e_epc();
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic tk;
        tk = e_take();
        if (rst) begin
            m_badv = 0; m_base = 0; m_compare = 0; m_epc = 0; m_elapsed = 0;
            m_ti = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_exc = 0; m_ipsw = 0;
            for (int i = 0; i < SS; i++) m_hist[i] = '0;
            return;
        end
        if (hit(5'd9)) begin
            m_base = wr_data;
            m_elapsed = 0;
        end else begin
            m_elapsed++;
            if ((m_elapsed % DIV) == 0 && m_count() == m_compare) m_ti = 1'b1;
        end
        if (hit(5'd11)) begin
            m_compare = wr_data;
            m_ti = 1'b0;
        end
        if (hit(5'd12)) begin
            m_ie = wr_data[0]; m_exl = wr_data[1]; m_im = wr_data[15:8];
        end
        if (eret) m_exl = 1'b0;
        if (hit(5'd13)) m_ipsw = wr_data[9:8];
        if (hit(5'd14)) m_epc = wr_data;
        if (tk) begin
            m_exl = 1'b1;
            m_bd  = exc_bd;
            m_exc = exc_valid ? exc_code : 5'd0;
            m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
            if (exc_valid && exc_badvaddr_we) m_badv = exc_badvaddr;
        end
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = 6'(hw_irq);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("take_exc", 32'(take_exc), 32'(e_take()));
        chk("epc_out", epc_out, e_epc());
        chk("timer_irq", 32'(timer_irq), 32'(m_ti));
        chk("rd_data", rd_data, e_rd());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_addr = a;
        rd_sel  = 3'd0;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic idle();
        wr_en = 0; wr_sel = 0; exc_valid = 0; exc_bd = 0; exc_badvaddr_we = 0;
        eret = 0; pipe_stall = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_sel = 0; wr_data = d;
        step();
        wr_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] addrs [8];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd20};
        rst = 1; rd_addr = 0; rd_sel = 0; wr_addr = 0; wr_data = 0; hw_irq = 0;
        exc_code = 0; exc_pc = 0; exc_badvaddr = 0;
        idle();
        repeat (3) step();
        rst = 0;
        rd_chk("count_rst", 5'd9, 32'h0);
        rd_chk("status_rst", 5'd12, 32'h0);

        repeat (10) step();
        rd_chk("count_idle10", 5'd9, 32'd5);
        chk("ti_idle", 32'(timer_irq), 32'h0);

        // Count/Compare interrupt
        mtc0(5'd11, 32'd8);
        mtc0(5'd12, 32'h0000_8001);
        exc_pc = 32'h400;
        for (int i = 0; i < 20 && timer_irq !== 1'b1; i++) step();
        chk("ti_set", 32'(timer_irq), 32'h1);
        rd_chk("count_at_ti", 5'd9, 32'd8);
        chk("take_on_ti", 32'(take_exc), 32'h1);
        step();
        rd_chk("cause_int", 5'd13, 32'h4000_8000);
        rd_chk("epc_int", 5'd14, 32'h400);
        rd_chk("status_exl", 5'd12, 32'h0000_8003);
        mtc0(5'd11, 32'h0010_0000);
        chk("ti_clr", 32'(timer_irq), 32'h0);
        eret = 1; step(); eret = 0;

        // Synchronous exception in a delay slot
        exc_valid = 1; exc_code = 5'd12; exc_bd = 1; exc_pc = 32'h100;
        #1;
        chk("take_ov", 32'(take_exc), 32'h1);
        step();
        chk("take_second", 32'(take_exc), 32'h0);
        rd_chk("epc_bd", 5'd14, 32'h0000_00FC);
        rd_chk("cause_ov", 5'd13, 32'h8000_0030);
        rd_chk("status_ov", 5'd12, 32'h0000_8003);
        step();
        idle();
        eret = 1; step(); eret = 0;

        // Stalled address-error exception
        exc_valid = 1; exc_code = 5'd4; exc_badvaddr_we = 1; exc_badvaddr = 32'h1003;
        exc_pc = 32'h200; pipe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("take_stalled", 32'(take_exc), 32'h0);
            step();
        end
        rd_chk("badv_stall", 5'd8, 32'h0);
        pipe_stall = 0;
        #1;
        chk("take_unstall", 32'(take_exc), 32'h1);
        step();
        idle();
        rd_chk("badv_loaded", 5'd8, 32'h1003);
        rd_chk("cause_adel", 5'd13, 32'h0000_0010);
        eret = 1; step(); eret = 0;

        // Hardware interrupt line 0 through the synchroniser
        mtc0(5'd12, 32'h0000_0401);
        hw_irq = 6'h01;
        step();
        rd_chk("ip2_one_edge", 5'd13, 32'h0000_0010);
        chk("take_one_edge", 32'(take_exc), 32'h0);
        step();
        rd_chk("ip2_two_edges", 5'd13, 32'h0000_0410);
        chk("take_hw", 32'(take_exc), 32'h1);
        step();
        chk("take_blocked_exl", 32'(take_exc), 32'h0);
        eret = 1; step(); eret = 0;
        #1;
        chk("take_reassert", 32'(take_exc), 32'h1);
        hw_irq = 6'h00;
        repeat (3) step();
        eret = 1; step(); eret = 0;

        // MTC0 Status and exception in the same cycle
        wr_en = 1; wr_addr = 5'd12; wr_data = 32'h0; exc_valid = 1; exc_code = 5'd8;
        #1;
        chk("take_with_mtc0", 32'(take_exc), 32'h1);
        step();
        idle();
        rd_chk("status_after_mtc0_exc", 5'd12, 32'h0000_0002);
        eret = 1; step(); eret = 0;

        // Compare clear beats a coincident match; wrap with Compare=0 sets TI
        mtc0(5'd11, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        mtc0(5'd11, 32'h0);
        chk("ti_clear_wins", 32'(timer_irq), 32'h0);
        rd_chk("count_wrapped", 5'd9, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFE);
        for (int i = 0; i < 10 && timer_irq !== 1'b1; i++) step();
        chk("ti_wrap", 32'(timer_irq), 32'h1);
        rd_chk("count_wrap_zero", 5'd9, 32'h0);

        // sel != 0 writes are dropped
        wr_en = 1; wr_addr = 5'd11; wr_sel = 3'd1; wr_data = 32'h5;
        step();
        idle();
        rd_chk("compare_sel1_ignored", 5'd11, 32'h0);

        // Randomized traffic with a mid-run reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                idle();
                rst = 1;
                repeat (2) step();
                rst = 0;
                hw_irq = 6'h3F;
                #1;
                chk("take_after_reset", 32'(take_exc), 32'h0);
                rd_chk("status_after_reset", 5'd12, 32'h0);
                rd_chk("count_after_reset", 5'd9, 32'h0);
            end
            wr_en           = ($urandom_range(0, 99) < 25);
            wr_addr         = addrs[$urandom_range(0, 7)];
            wr_sel          = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd0;
            wr_data         = $urandom;
            exc_valid       = ($urandom_range(0, 9) == 0);
            exc_code        = 5'($urandom);
            exc_bd          = 1'($urandom);
            exc_pc          = $urandom & 32'hFFFF_FFFC;
            exc_badvaddr_we = 1'($urandom);
            exc_badvaddr    = $urandom;
            eret            = ($urandom_range(0, 7) == 0);
            pipe_stall      = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) hw_irq = 6'($urandom);
            rd_addr         = addrs[$urandom_range(0, 7)];
            rd_sel          = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd0;
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
